// File: rtl/scr1_tcm_pkg.sv
// Shared types and helpers for the banked TCM: response-pipe entry, byte enables, legality.
// Latency: none (pure types and combinational functions).
// Backpressure: not applicable.
package scr1_tcm_pkg;

`include "scr1_memif.svh"

    // One slot of a per-port response pipe.
    typedef struct packed {
        logic       valid;
        logic       err;
        logic [1:0] shift;   // byte offset used to right-align read data
    } type_scr1_tcm_rsp_s;

    function automatic logic [3:0] scr1_tcm_byteen(input type_scr1_mem_width_e width,
                                                   input logic [1:0]           addr_lo);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  return 4'b0001 << addr_lo;
            SCR1_MEM_WIDTH_HWORD: return 4'b0011 << {addr_lo[1], 1'b0};
            default:              return 4'b1111;
        endcase
    endfunction

    // Range and alignment check common to both ports; the imem read-only rule is applied by the caller.
    function automatic logic scr1_tcm_legal(input type_scr1_mem_cmd_e   cmd,
                                            input type_scr1_mem_width_e width,
                                            input logic [31:0]          addr,
                                            input logic [31:0]          size);
        logic aligned;
        case (width)
            SCR1_MEM_WIDTH_BYTE:  aligned = 1'b1;
            SCR1_MEM_WIDTH_HWORD: aligned = ~addr[0];
            SCR1_MEM_WIDTH_WORD:  aligned = (addr[1:0] == 2'b00);
            default:              aligned = 1'b0;   // reserved width encoding
        endcase
        return aligned && (addr < size) && (cmd inside {SCR1_MEM_CMD_RD, SCR1_MEM_CMD_WR});
    endfunction

    function automatic type_scr1_mem_resp_e scr1_tcm_resp(input type_scr1_tcm_rsp_s r);
        if (!r.valid) return SCR1_MEM_RESP_NOTRDY;
        return r.err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    endfunction

endpackage

// File: rtl/scr1_memif.svh
// Memory-interface typedefs shared by the core, the TCM and the router.
// Pulled into scr1_tcm_pkg so every TCM file sees one definition.
// Included once only; the guard keeps repeated includes harmless.
`ifndef SCR1_MEMIF_SVH
`define SCR1_MEMIF_SVH

localparam int SCR1_IMEM_AWIDTH = 32;
localparam int SCR1_IMEM_DWIDTH = 32;
localparam int SCR1_DMEM_AWIDTH = 32;
localparam int SCR1_DMEM_DWIDTH = 32;

typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
} type_scr1_mem_cmd_e;

typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
} type_scr1_mem_width_e;

typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
} type_scr1_mem_resp_e;

`endif

// File: rtl/scr1_tcm_bank.sv
// Single-port 32-bit RAM bank with byte write enables and a registered read port.
// Latency: read data valid the cycle after en & ~we; writes complete at the clock edge.
// Backpressure: none; one access per cycle whenever en is high. Contents are never reset.
module scr1_tcm_bank #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    byteen,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/scr1_tcm_banked.sv
// Banked TCM: word-interleaved banks shared by imem/dmem with dmem priority and imem anti-starvation.
// Latency: response 1+SCR1_TCM_RD_PIPE cycles after accept, one request per port per cycle.
// Backpressure: req_ack low on a lost bank conflict; illegal requests are acked at once and answer RDY_ER.
// Ports: clk/rst_n; imem_{req,req_ack,cmd,addr,rdata,resp}; dmem_{req,req_ack,cmd,width,addr,wdata,rdata,resp}.
module scr1_tcm_banked
    import scr1_tcm_pkg::*;
#(
    parameter logic [SCR1_IMEM_AWIDTH-1:0] SCR1_TCM_SIZE       = 32'h0001_0000,
    parameter int                          SCR1_TCM_BANKS      = 2,
    parameter int                          SCR1_TCM_RD_PIPE    = 0,
    parameter int                          SCR1_TCM_STARVE_MAX = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        imem_req,
    output logic                        imem_req_ack,
    input  type_scr1_mem_cmd_e          imem_cmd,
    input  logic [SCR1_IMEM_AWIDTH-1:0] imem_addr,
    output logic [SCR1_IMEM_DWIDTH-1:0] imem_rdata,
    output type_scr1_mem_resp_e         imem_resp,
    input  logic                        dmem_req,
    output logic                        dmem_req_ack,
    input  type_scr1_mem_cmd_e          dmem_cmd,
    input  type_scr1_mem_width_e        dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e         dmem_resp
);
    localparam int LB  = $clog2(SCR1_TCM_BANKS);
    localparam int BIW = (LB > 0) ? LB : 1;
    localparam int WW  = $clog2(SCR1_TCM_SIZE) - 2 - LB;

    logic           i_legal, d_legal, conflict, imem_win;
    logic [BIW-1:0] i_bank, d_bank;
    logic [WW-1:0]  i_widx, d_widx;
    logic [3:0]     d_byteen;
    logic [31:0]    d_wdata_rep;
    logic [3:0]     starve_cnt;

    // Port index 0 = imem, 1 = dmem throughout the response path.
    type_scr1_tcm_rsp_s rsp_new [2];
    type_scr1_tcm_rsp_s rsp_q   [2];
    type_scr1_tcm_rsp_s rsp_out [2];
    logic [BIW-1:0]     bank_q  [2];
    logic [31:0]        rd_shift  [2];
    logic [31:0]        rdata_out [2];
    logic [31:0]        bank_rdata [SCR1_TCM_BANKS];

    always_comb begin
        i_legal = scr1_tcm_legal(imem_cmd, SCR1_MEM_WIDTH_WORD, imem_addr, SCR1_TCM_SIZE)
                  && (imem_cmd == SCR1_MEM_CMD_RD);
        d_legal = scr1_tcm_legal(dmem_cmd, dmem_width, dmem_addr, SCR1_TCM_SIZE);
        i_bank  = '0;
        d_bank  = '0;
        if (LB > 0) begin
            i_bank = imem_addr[2 +: BIW];
            d_bank = dmem_addr[2 +: BIW];
        end
        i_widx = imem_addr[2+LB +: WW];
        d_widx = dmem_addr[2+LB +: WW];

        // Only two legal requests can collide; an illegal one never reaches a bank.
        conflict     = imem_req & dmem_req & i_legal & d_legal & (i_bank == d_bank);
        imem_win     = (starve_cnt == 4'(SCR1_TCM_STARVE_MAX));
        imem_req_ack = imem_req & ~(conflict & ~imem_win);
        dmem_req_ack = dmem_req & ~(conflict &  imem_win);

        d_byteen = scr1_tcm_byteen(dmem_width, dmem_addr[1:0]);
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE:  d_wdata_rep = {4{dmem_wdata[7:0]}};
            SCR1_MEM_WIDTH_HWORD: d_wdata_rep = {2{dmem_wdata[15:0]}};
            default:              d_wdata_rep = dmem_wdata;
        endcase

        rsp_new[0] = '{valid: imem_req_ack, err: ~i_legal, shift: 2'b00};
        rsp_new[1] = '{valid: dmem_req_ack, err: ~d_legal, shift: dmem_addr[1:0]};
    end

    // A denied imem request only ever loses to dmem on a conflict, so any
    // un-acked cycle with imem_req high counts as one denial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!imem_req || imem_req_ack) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    for (genvar b = 0; b < SCR1_TCM_BANKS; b++) begin : g_bank
        logic i_sel, d_sel;
        assign i_sel = imem_req_ack & i_legal & (i_bank == BIW'(b));
        assign d_sel = dmem_req_ack & d_legal & (d_bank == BIW'(b));

        scr1_tcm_bank #(.AW(WW)) u_bank (
            .clk    (clk),
            .en     (i_sel | d_sel),
            .we     (d_sel & (dmem_cmd == SCR1_MEM_CMD_WR)),
            .addr   (d_sel ? d_widx : i_widx),
            .byteen (d_byteen),
            .wdata  (d_wdata_rep),
            .rdata  (bank_rdata[b])
        );
    end

    // First response stage lines up with the bank's registered read; the
    // captured bank index steers the read mux for that port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                rsp_q[p]  <= '0;
                bank_q[p] <= '0;
            end
        end else begin
            rsp_q[0]  <= rsp_new[0];
            rsp_q[1]  <= rsp_new[1];
            bank_q[0] <= i_bank;
            bank_q[1] <= d_bank;
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_shift[p] = bank_rdata[bank_q[p]] >> {rsp_q[p].shift, 3'b000};
        end
    end

    if (SCR1_TCM_RD_PIPE == 0) begin : g_nopipe
        always_comb begin
            for (int p = 0; p < 2; p++) begin
                rsp_out[p]   = rsp_q[p];
                rdata_out[p] = rd_shift[p];
            end
        end
    end else begin : g_pipe
        type_scr1_tcm_rsp_s rsp_p   [2];
        logic [31:0]        rdata_p [2];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int p = 0; p < 2; p++) begin
                    rsp_p[p]   <= '0;
                    rdata_p[p] <= '0;
                end
            end else begin
                for (int p = 0; p < 2; p++) begin
                    rsp_p[p]   <= rsp_q[p];
                    rdata_p[p] <= rd_shift[p];
                end
            end
        end

        always_comb begin
            for (int p = 0; p < 2; p++) begin
                rsp_out[p]   = rsp_p[p];
                rdata_out[p] = rdata_p[p];
            end
        end
    end

    assign imem_resp  = scr1_tcm_resp(rsp_out[0]);
    assign dmem_resp  = scr1_tcm_resp(rsp_out[1]);
    assign imem_rdata = rdata_out[0];
    assign dmem_rdata = rdata_out[1];
endmodule
